// File: rtl/serial_link_obi_arbiter_if.sv
// ---------------------------------------------------------------------------
// serial_link_obi_arbiter_if
// Bundles every bus signal of the serial-link OBI arbiter. The signal names
// keep their _i/_o suffixes as seen from the arbiter.
//
//   Upstream side (NumReq OBI masters):
//     s_req_i, s_addr_i, s_we_i, s_be_i, s_wdata_i    : packed per master,
//                                                       master k in slice k
//     s_gnt_o, s_rvalid_o                              : one bit per master
//     s_rdata_o                                        : broadcast data
//   Downstream side (single serial-link OBI port):
//     m_req_o, m_addr_o, m_we_o, m_be_o, m_wdata_o, m_gnt_i, m_rvalid_i,
//     m_rdata_i
//   Status:
//     busy_o, err_unexp_rvalid_o, stall_cnt_o (16 bits per master)
//
// Modports:
//   slave  : the arbiter's view (drives the *_o signals)
//   master : the surrounding system's view (drives the *_i signals)
//
// The parameters must match those of the arbiter instance using it.
// ---------------------------------------------------------------------------
interface serial_link_obi_arbiter_if #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  logic [NumReq-1:0]             s_req_i;
  logic [NumReq*AddrWidth-1:0]   s_addr_i;
  logic [NumReq-1:0]             s_we_i;
  logic [NumReq*DataWidth/8-1:0] s_be_i;
  logic [NumReq*DataWidth-1:0]   s_wdata_i;
  logic [NumReq-1:0]             s_gnt_o;
  logic [NumReq-1:0]             s_rvalid_o;
  logic [DataWidth-1:0]          s_rdata_o;
  logic                          m_req_o;
  logic [AddrWidth-1:0]          m_addr_o;
  logic                          m_we_o;
  logic [DataWidth/8-1:0]        m_be_o;
  logic [DataWidth-1:0]          m_wdata_o;
  logic                          m_gnt_i;
  logic                          m_rvalid_i;
  logic [DataWidth-1:0]          m_rdata_i;
  logic                          busy_o;
  logic                          err_unexp_rvalid_o;
  logic [NumReq*16-1:0]          stall_cnt_o;

  modport slave (
    input  s_req_i, s_addr_i, s_we_i, s_be_i, s_wdata_i,
    input  m_gnt_i, m_rvalid_i, m_rdata_i,
    output s_gnt_o, s_rvalid_o, s_rdata_o,
    output m_req_o, m_addr_o, m_we_o, m_be_o, m_wdata_o,
    output busy_o, err_unexp_rvalid_o, stall_cnt_o
  );

  modport master (
    output s_req_i, s_addr_i, s_we_i, s_be_i, s_wdata_i,
    output m_gnt_i, m_rvalid_i, m_rdata_i,
    input  s_gnt_o, s_rvalid_o, s_rdata_o,
    input  m_req_o, m_addr_o, m_we_o, m_be_o, m_wdata_o,
    input  busy_o, err_unexp_rvalid_o, stall_cnt_o
  );
endinterface

// File: rtl/serial_link_obi_arbiter.sv
// ---------------------------------------------------------------------------
// serial_link_obi_arbiter
// Round-robin arbiter that shares the single OBI port of the serial-link
// bridge among NumReq OBI masters. Issued transactions are remembered in an
// ID FIFO (issue order) so every response is routed back to its originator.
//
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : serial_link_obi_arbiter_if.slave (all request/response/status
//            signals, see the interface file)
//
// Parameters:
//   NumReq         : number of upstream masters (>= 2)
//   MaxOutstanding : issued-but-unanswered limit (bridge FIFO depth)
//   AddrWidth      : OBI address width
//   DataWidth      : OBI data width (byte enables are DataWidth/8)
//
// Optional feature, macro SERIAL_LINK_OBI_ARB_STALL_CNT_EN:
//   defined   -> per-master 16-bit saturating stall counters on stall_cnt_o
//   undefined -> no counters, stall_cnt_o tied to 0
// ---------------------------------------------------------------------------
module serial_link_obi_arbiter #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  serial_link_obi_arbiter_if.slave bus
);

  localparam int unsigned IdW  = $clog2(NumReq);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned BeW  = DataWidth / 8;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  lock_state_e          lock_state_reg, lock_state_next;
  logic [IdW-1:0]       locked_idx_reg, locked_idx_next;
  logic [IdW-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [CntW-1:0]      count_reg, count_next;
  logic [PtrW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic                 err_reg;
  logic [IdW-1:0]       id_mem [MaxOutstanding];

  logic [NumReq-1:0]    ptr_mask;
  logic [NumReq-1:0]    masked_req;
  logic [IdW-1:0]       hi_idx, lo_idx, rr_winner, sel_idx, head_idx;
  logic                 any_req, full, m_req, handshake, pop;
  logic [NumReq-1:0]    gnt, rvalid;

  logic [AddrWidth-1:0] addr_arr  [NumReq];
  logic [BeW-1:0]       be_arr    [NumReq];
  logic [DataWidth-1:0] wdata_arr [NumReq];

  // Unpack the per-master slices and build the "at or after rr_ptr" mask.
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_slice
    assign addr_arr[gi]  = bus.s_addr_i[gi*AddrWidth +: AddrWidth];
    assign be_arr[gi]    = bus.s_be_i[gi*BeW +: BeW];
    assign wdata_arr[gi] = bus.s_wdata_i[gi*DataWidth +: DataWidth];
    assign ptr_mask[gi]  = (IdW'(gi) >= rr_ptr_reg);
  end

  assign masked_req = bus.s_req_i & ptr_mask;

  // Lowest requester at/after rr_ptr, falling back to the lowest requester
  // overall; together this is a modulo-NumReq search starting at rr_ptr.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      if (masked_req[i])    hi_idx = IdW'(i);
      if (bus.s_req_i[i])   lo_idx = IdW'(i);
    end
  end

  assign rr_winner = (|masked_req) ? hi_idx : lo_idx;

  // ---- Lock FSM: state register ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_state_reg <= UNLOCKED;
      locked_idx_reg <= '0;
    end else begin
      lock_state_reg <= lock_state_next;
      locked_idx_reg <= locked_idx_next;
    end
  end

  // ---- Lock FSM: next state ----
  // An address phase that was offered but not granted must be held stable,
  // so the current selection is frozen until its handshake.
  always_comb begin
    lock_state_next = lock_state_reg;
    locked_idx_next = locked_idx_reg;
    if (handshake) begin
      lock_state_next = UNLOCKED;
    end else if (m_req) begin
      lock_state_next = LOCKED;
      locked_idx_next = sel_idx;
    end
  end

  // ---- Lock FSM: outputs ----
  always_comb begin
    sel_idx   = (lock_state_reg == LOCKED) ? locked_idx_reg : rr_winner;
    any_req   = |bus.s_req_i;
    full      = (count_reg == CntW'(MaxOutstanding));
    m_req     = any_req && !full;
    handshake = m_req && bus.m_gnt_i;
    pop       = bus.m_rvalid_i && (count_reg != '0);
  end

  // ---- Round-robin pointer and outstanding count ----
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (handshake) begin
      rr_ptr_next = (sel_idx == IdW'(NumReq - 1)) ? '0 : sel_idx + 1'b1;
    end
    count_next = count_reg;
    case ({handshake, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_reg <= '0;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      count_reg  <= count_next;
      if (handshake) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)       rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      // A response with nothing outstanding is dropped and flagged for good.
      if (bus.m_rvalid_i && (count_reg == '0)) err_reg <= 1'b1;
    end
  end

  // ID storage needs no reset: entries are only read while count > 0.
  always_ff @(posedge clk_i) begin
    if (handshake) id_mem[wr_ptr_reg] <= sel_idx;
  end

  assign head_idx = id_mem[rd_ptr_reg];

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_route
    assign gnt[gi]    = handshake && (sel_idx == IdW'(gi));
    assign rvalid[gi] = pop && (head_idx == IdW'(gi));
  end

  assign bus.s_gnt_o            = gnt;
  assign bus.s_rvalid_o         = rvalid;
  assign bus.s_rdata_o          = bus.m_rdata_i;
  assign bus.m_req_o            = m_req;
  assign bus.m_addr_o           = addr_arr[sel_idx];
  assign bus.m_we_o             = bus.s_we_i[sel_idx];
  assign bus.m_be_o             = be_arr[sel_idx];
  assign bus.m_wdata_o          = wdata_arr[sel_idx];
  assign bus.busy_o             = (count_reg != '0);
  assign bus.err_unexp_rvalid_o = err_reg;

`ifdef SERIAL_LINK_OBI_ARB_STALL_CNT_EN
  // Cycles spent requesting without a grant, saturating at 0xFFFF.
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_stall
    logic [15:0] stall_cnt_reg;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stall_cnt_reg <= '0;
      end else if (bus.s_req_i[gi] && !gnt[gi] && (stall_cnt_reg != 16'hFFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
    end
    assign bus.stall_cnt_o[gi*16 +: 16] = stall_cnt_reg;
  end
`else
  assign bus.stall_cnt_o = '0;
`endif

endmodule
